accum_stream_arbiter: RTL

//  Shares one AXI-Stream frame accumulator (N-beat sum -> two 7-seg digits) among M requesters.
//  - Locks a grant for a whole N-beat frame and forwards its beats to the accumulator.
//  - Waits for the accumulator result and returns it downstream, tagged with the requester ID.
//  - Sits between the requester streams and the accumulator instance.

---
 rtl/accum_stream_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/accum_stream_arbiter.sv
// Round-robin arbiter that shares one N-beat frame accumulator among M stream requesters.
// Optional idle watchdog with zero padding of stalled frames: define ARB_TIMEOUT_EN.
module accum_stream_arbiter #(
  parameter int unsigned W       = 3,
  parameter int unsigned N       = 5,
  parameter int unsigned M       = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [M-1:0]         s_valid,
  input  logic [M*W-1:0]       s_data,
  output logic [M-1:0]         s_ready,
  output logic                 acc_valid,
  output logic [W-1:0]         acc_data,
  input  logic                 acc_ready,
  input  logic                 acc_res_valid,
  input  logic [13:0]          acc_res_data,
  output logic                 acc_res_ready,
  output logic                 m_valid,
  output logic [13:0]          m_data,
  output logic [$clog2(M)-1:0] m_id,
  output logic                 m_err,
  input  logic                 m_ready
);

  localparam int unsigned IDW = $clog2(M);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES, DELIVER} state_t;

  state_t         state;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] rr_ptr;
  logic [3:0]     beat_cnt;
  logic           pad;

  logic           pick_vld;
  logic [IDW-1:0] pick_idx;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] rr_next;
  logic           acc_hs;

  // Round-robin pick: first active requester at or after rr_ptr, wrapping at M
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned k = 0; k < M; k++) begin
      cand = IDW'((32'(rr_ptr) + k) % M);
      if (!pick_vld && s_valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
    rr_next = IDW'((32'(pick_idx) + 1) % M);
  end

  // Beat mux toward the accumulator; a padded frame feeds zeros without touching the requester
  always_comb begin
    s_ready   = '0;
    acc_valid = 1'b0;
    acc_data  = '0;
    if (state == STREAM) begin
      if (pad) begin
        acc_valid = 1'b1;
      end else begin
        acc_valid      = s_valid[grant];
        acc_data       = s_data[32'(grant) * W +: W];
        s_ready[grant] = acc_ready;
      end
    end
  end

  assign acc_hs = acc_valid && acc_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      grant         <= '0;
      rr_ptr        <= '0;
      beat_cnt      <= '0;
      acc_res_ready <= 1'b0;
      m_valid       <= 1'b0;
      m_data        <= '0;
      m_id          <= '0;
      m_err         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant    <= pick_idx;
            rr_ptr   <= rr_next;
            beat_cnt <= '0;
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (acc_hs) begin
            beat_cnt <= beat_cnt + 4'd1;
            if (beat_cnt == 4'(N - 1)) begin
              acc_res_ready <= 1'b1;
              state         <= WAIT_RES;
            end
          end
        end
        WAIT_RES: begin
          if (acc_res_valid) begin
            acc_res_ready <= 1'b0;
            m_valid       <= 1'b1;
            m_data        <= acc_res_data;
            m_id          <= grant;
            m_err         <= pad;
            state         <= DELIVER;
          end
        end
        DELIVER: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TCW = $clog2(TIMEOUT);

  logic [TCW-1:0] stall_cnt;

  // Watchdog: after TIMEOUT consecutive empty cycles the rest of the frame is zero-padded
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
      pad       <= 1'b0;
    end else if (state == IDLE) begin
      stall_cnt <= '0;
      pad       <= 1'b0;
    end else if (state == STREAM && !pad) begin
      if (s_valid[grant]) begin
        stall_cnt <= '0;
      end else if (stall_cnt == TCW'(TIMEOUT - 1)) begin
        pad <= 1'b1;
      end else begin
        stall_cnt <= stall_cnt + TCW'(1);
      end
    end
  end
`else
  assign pad = 1'b0;
`endif

endmodule
